// File: rtl/ex_pkg.sv
// Shared opcode/funct encodings for the execute stage.
// Also holds the load/store opcode range helper.
package ex_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_BLEZ    = 6'd6;
  localparam logic [5:0] OP_BGTZ    = 6'd7;
  localparam logic [5:0] OP_ADDI    = 6'd8;
  localparam logic [5:0] OP_ADDIU   = 6'd9;
  localparam logic [5:0] OP_SLTI    = 6'd10;
  localparam logic [5:0] OP_SLTIU   = 6'd11;
  localparam logic [5:0] OP_ANDI    = 6'd12;
  localparam logic [5:0] OP_ORI     = 6'd13;
  localparam logic [5:0] OP_XORI    = 6'd14;
  localparam logic [5:0] OP_LUI     = 6'd15;
  localparam logic [5:0] OP_MEM_LO  = 6'h20;
  localparam logic [5:0] OP_MEM_HI  = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_SRA   = 6'd3;
  localparam logic [5:0] FN_SLLV  = 6'd4;
  localparam logic [5:0] FN_SRLV  = 6'd6;
  localparam logic [5:0] FN_SRAV  = 6'd7;
  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_JALR  = 6'd9;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SUBU  = 6'd35;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_XOR   = 6'd38;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLTU  = 6'd43;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op >= OP_MEM_LO) && (op <= OP_MEM_HI);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// HI/LO register pair with move-to, multiply and divide updates.
// Instantiated by ex_stage only when EX_MULDIV_EN is defined.
module ex_muldiv
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  fn,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'h0, rs} * {32'h0, rt};

  // Divider never sees zero; a zero divisor simply suppresses the update below.
  assign divisor = (rt == 32'h0) ? 32'h1 : rt;
  assign quot_s  = $signed(rs) / $signed(divisor);
  assign rem_s   = $signed(rs) % $signed(divisor);
  assign quot_u  = rs / divisor;
  assign rem_u   = rs % divisor;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (op == OP_SPECIAL) begin
      case (fn)
        FN_MTHI:  hi_d = rs;
        FN_MTLO:  lo_d = rs;
        FN_MULT:  {hi_d, lo_d} = prod_s;
        FN_MULTU: {hi_d, lo_d} = prod_u;
        FN_DIV: begin
          if (rt != 32'h0) begin
            lo_d = quot_s;
            hi_d = rem_s;
          end
        end
        FN_DIVU: begin
          if (rt != 32'h0) begin
            lo_d = quot_u;
            hi_d = rem_u;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Combinational execute stage: ALU, shifts, branches and jumps.
// HI/LO multiply/divide support is built only with EX_MULDIV_EN defined.
module ex_stage
  import ex_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] Rdata1,
  input  logic [31:0] Rdata2,
  input  logic [5:0]  ALU,
  input  logic [5:0]  Op,
  input  logic [31:0] Ed32,
  input  logic [25:0] Jadr,
  input  logic [31:0] nextPC,
  output logic [31:0] newPC,
  output logic [31:0] Result
);

  logic [4:0]  shamt;
  logic [4:0]  shvar;
  logic [31:0] sra_imm, sra_var;
  logic [31:0] imm_zext;
  logic [31:0] br_target;
  logic [31:0] result_c, new_pc_c;

`ifdef EX_MULDIV_EN
  logic [31:0] hi, lo;

  ex_muldiv u_muldiv (
    .clk   (CLK),
    .rst_n (RSTN),
    .op    (Op),
    .fn    (ALU),
    .rs    (Rdata1),
    .rt    (Rdata2),
    .hi    (hi),
    .lo    (lo)
  );
`else
  logic unused_clk_rst;
  assign unused_clk_rst = CLK ^ RSTN;
`endif

  assign shamt     = Ed32[10:6];
  assign shvar     = Rdata1[4:0];
  assign sra_imm   = $signed(Rdata2) >>> shamt;
  assign sra_var   = $signed(Rdata2) >>> shvar;
  assign imm_zext  = {16'h0, Ed32[15:0]};
  assign br_target = nextPC + {Ed32[29:0], 2'b00};

  always_comb begin
    result_c = 32'h0;
    new_pc_c = nextPC;
    case (Op)
      OP_SPECIAL: begin
        case (ALU)
          FN_ADD, FN_ADDU: result_c = Rdata1 + Rdata2;
          FN_SUB, FN_SUBU: result_c = Rdata1 - Rdata2;
          FN_AND:  result_c = Rdata1 & Rdata2;
          FN_OR:   result_c = Rdata1 | Rdata2;
          FN_XOR:  result_c = Rdata1 ^ Rdata2;
          FN_NOR:  result_c = ~(Rdata1 | Rdata2);
          FN_SLT:  result_c = ($signed(Rdata1) < $signed(Rdata2)) ? 32'h1 : 32'h0;
          FN_SLTU: result_c = (Rdata1 < Rdata2) ? 32'h1 : 32'h0;
          FN_SLL:  result_c = Rdata2 << shamt;
          FN_SRL:  result_c = Rdata2 >> shamt;
          FN_SRA:  result_c = sra_imm;
          FN_SLLV: result_c = Rdata2 << shvar;
          FN_SRLV: result_c = Rdata2 >> shvar;
          FN_SRAV: result_c = sra_var;
          FN_JR:   new_pc_c = Rdata1;
          FN_JALR: begin
            new_pc_c = Rdata1;
            result_c = nextPC;
          end
`ifdef EX_MULDIV_EN
          FN_MFHI: result_c = hi;
          FN_MFLO: result_c = lo;
`endif
          default: ;
        endcase
      end
      OP_J:     new_pc_c = {nextPC[31:28], Jadr, 2'b00};
      OP_JAL: begin
        new_pc_c = {nextPC[31:28], Jadr, 2'b00};
        result_c = nextPC;
      end
      OP_BEQ:   if (Rdata1 == Rdata2) new_pc_c = br_target;
      OP_BNE:   if (Rdata1 != Rdata2) new_pc_c = br_target;
      OP_BLEZ:  if (Rdata1[31] || (Rdata1 == 32'h0)) new_pc_c = br_target;
      OP_BGTZ:  if (!Rdata1[31] && (Rdata1 != 32'h0)) new_pc_c = br_target;
      OP_ADDI, OP_ADDIU: result_c = Rdata1 + Ed32;
      OP_SLTI:  result_c = ($signed(Rdata1) < $signed(Ed32)) ? 32'h1 : 32'h0;
      OP_SLTIU: result_c = (Rdata1 < Ed32) ? 32'h1 : 32'h0;
      OP_ANDI:  result_c = Rdata1 & imm_zext;
      OP_ORI:   result_c = Rdata1 | imm_zext;
      OP_XORI:  result_c = Rdata1 ^ imm_zext;
      OP_LUI:   result_c = {Ed32[15:0], 16'h0};
      default: begin
        // Loads and stores only need the effective address.
        if (is_mem_op(Op)) result_c = Rdata1 + Ed32;
      end
    endcase
  end

  assign Result = result_c;
  assign newPC  = new_pc_c;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage; HI/LO expectations depend on EX_MULDIV_EN.
module tb_ex_stage;

`ifdef EX_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [31:0] Rdata1 = '0, Rdata2 = '0, Ed32 = '0, nextPC = '0;
  logic [5:0]  ALU = '0, Op = '0;
  logic [25:0] Jadr = '0;
  logic [31:0] newPC, Result;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ex_stage dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .Rdata1 (Rdata1),
    .Rdata2 (Rdata2),
    .ALU    (ALU),
    .Op     (Op),
    .Ed32   (Ed32),
    .Jadr   (Jadr),
    .nextPC (nextPC),
    .newPC  (newPC),
    .Result (Result)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] md(input logic [31:0] v);
    return MD ? v : 32'h0;
  endfunction

  // Drive one instruction, check its outputs mid-cycle, then let the clock edge commit it.
  task automatic txn(input string tag, input logic [5:0] op, input logic [5:0] alu,
                     input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] ed,
                     input logic [25:0] ja, input logic [31:0] npc,
                     input logic [31:0] exp_res, input logic [31:0] exp_pc);
    exp_t e;
    Op = op; ALU = alu; Rdata1 = r1; Rdata2 = r2; Ed32 = ed; Jadr = ja; nextPC = npc;
    sb.push_back('{res: exp_res, pc: exp_pc});
    @(negedge CLK);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      check({tag, "_res"}, Result, e.res);
      check({tag, "_pc"}, newPC, e.pc);
    end
    $display("txn %-10s op=%0d alu=%0d r1=%h r2=%h ed=%h -> Result=%h newPC=%h",
             tag, op, alu, r1, r2, ed, Result, newPC);
    @(posedge CLK);
    #1;
  endtask

  localparam logic [31:0] NPC = 32'h0000_0100;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    txn("rst_mfhi", 6'd0, 6'd16, 32'h0, 32'h0, 32'h0, 26'h0, NPC, 32'h0, NPC);
    RSTN = 1'b1;
    txn("init_mflo", 6'd0, 6'd18, 32'h0, 32'h0, 32'h0, 26'h0, NPC, 32'h0, NPC);

    txn("add", 6'd0, 6'd32, 32'h1, 32'h1, 32'h0, 26'h0, NPC, 32'h2, NPC);
    txn("nor", 6'd0, 6'd39, 32'h1, 32'h1, 32'h0, 26'h0, NPC, 32'hFFFF_FFFE, NPC);
    txn("sub_wrap", 6'd0, 6'd34, 32'h1, 32'h2, 32'h0, 26'h0, NPC, 32'hFFFF_FFFF, NPC);
    txn("addu_wrap", 6'd0, 6'd33, 32'hFFFF_FFFF, 32'h1, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("xor", 6'd0, 6'd38, 32'hF0F0_1234, 32'h0FF0_1200, 32'h0, 26'h0, NPC, 32'hFF00_0034, NPC);
    txn("slt_eq", 6'd0, 6'd42, 32'h1, 32'h1, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("slt_lt", 6'd0, 6'd42, 32'h1, 32'h4, 32'h0, 26'h0, NPC, 32'h1, NPC);
    txn("slt_neg", 6'd0, 6'd42, 32'hFFFF_FFFF, 32'h1, 32'h0, 26'h0, NPC, 32'h1, NPC);
    txn("sltu_big", 6'd0, 6'd43, 32'hFFFF_FFFF, 32'h1, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("slti", 6'd10, 6'd0, 32'h1, 32'h0, 32'h4, 26'h0, NPC, 32'h1, NPC);
    txn("sltiu", 6'd11, 6'd0, 32'h1, 32'h0, 32'hFFFF_FFFF, 26'h0, NPC, 32'h1, NPC);

    txn("sra", 6'd0, 6'd3, 32'h0, 32'h8000_0000, 32'h100, 26'h0, NPC, 32'hF800_0000, NPC);
    txn("srl", 6'd0, 6'd2, 32'h0, 32'h8000_0000, 32'h100, 26'h0, NPC, 32'h0800_0000, NPC);
    txn("sll", 6'd0, 6'd0, 32'h0, 32'h1, 32'h100, 26'h0, NPC, 32'h10, NPC);
    txn("srav", 6'd0, 6'd7, 32'h24, 32'h8000_0000, 32'h0, 26'h0, NPC, 32'hF800_0000, NPC);
    txn("sllv", 6'd0, 6'd4, 32'h1F, 32'h1, 32'h0, 26'h0, NPC, 32'h8000_0000, NPC);

    txn("lui", 6'd15, 6'd0, 32'h0, 32'h0, 32'h1234, 26'h0, NPC, 32'h1234_0000, NPC);
    txn("ori_zext", 6'd13, 6'd0, 32'hF000_0000, 32'h0, 32'hFFFF_8001, 26'h0, NPC, 32'hF000_8001, NPC);
    txn("addi", 6'd8, 6'd0, 32'h10, 32'h0, 32'hFFFF_FFFF, 26'h0, NPC, 32'hF, NPC);
    txn("lw_addr", 6'h23, 6'd0, 32'h1000, 32'h0, 32'hFFFF_FFFC, 26'h0, NPC, 32'h0FFC, NPC);
    txn("sw_addr", 6'h2B, 6'd0, 32'h1000, 32'h0, 32'h8, 26'h0, NPC, 32'h1008, NPC);
    txn("op1_undef", 6'd1, 6'd0, 32'h5, 32'h5, 32'h5, 26'h0, NPC, 32'h0, NPC);
    txn("op2c_mem", 6'h2C, 6'd0, 32'h5, 32'h5, 32'h5, 26'h0, NPC, 32'h0, NPC);

    txn("j", 6'd2, 6'd0, 32'h0, 32'h0, 32'h0, 26'h1, 32'h4000_0004, 32'h0, 32'h4000_0004);
    txn("jal", 6'd3, 6'd0, 32'h0, 32'h0, 32'h0, 26'h3F_FFFF, 32'h4000_0004, 32'h4000_0004, 32'h40FF_FFFC);
    txn("beq_taken", 6'd4, 6'd0, 32'h7, 32'h7, 32'hFFFF_FFFF, 26'h0, 32'h8, 32'h0, 32'h4);
    txn("bne_nt", 6'd5, 6'd0, 32'h7, 32'h7, 32'h10, 26'h0, 32'h8, 32'h0, 32'h8);
    txn("blez_zero", 6'd6, 6'd0, 32'h0, 32'h0, 32'h10, 26'h0, 32'h8, 32'h0, 32'h48);
    txn("bgtz_zero", 6'd7, 6'd0, 32'h0, 32'h0, 32'h10, 26'h0, 32'h8, 32'h0, 32'h8);
    txn("jr", 6'd0, 6'd8, 32'h300, 32'h0, 32'h0, 26'h0, NPC, 32'h0, 32'h300);
    txn("jalr", 6'd0, 6'd9, 32'h300, 32'h0, 32'h0, 26'h0, NPC, NPC, 32'h300);

    txn("mult", 6'd0, 6'd24, 32'hFFFF_FFFF, 32'h2, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("mult_hi", 6'd0, 6'd16, 32'h0, 32'h0, 32'h0, 26'h0, NPC, md(32'hFFFF_FFFF), NPC);
    txn("mult_lo", 6'd0, 6'd18, 32'h0, 32'h0, 32'h0, 26'h0, NPC, md(32'hFFFF_FFFE), NPC);
    txn("multu", 6'd0, 6'd25, 32'hFFFF_FFFF, 32'h2, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("multu_hi", 6'd0, 6'd16, 32'h0, 32'h0, 32'h0, 26'h0, NPC, md(32'h1), NPC);
    txn("multu_lo", 6'd0, 6'd18, 32'h0, 32'h0, 32'h0, 26'h0, NPC, md(32'hFFFF_FFFE), NPC);
    txn("div", 6'd0, 6'd26, 32'hFFFF_FFF9, 32'h2, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("div_lo", 6'd0, 6'd18, 32'h0, 32'h0, 32'h0, 26'h0, NPC, md(32'hFFFF_FFFD), NPC);
    txn("div_hi", 6'd0, 6'd16, 32'h0, 32'h0, 32'h0, 26'h0, NPC, md(32'hFFFF_FFFF), NPC);
    txn("divu", 6'd0, 6'd27, 32'h7, 32'h2, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("div_zero", 6'd0, 6'd26, 32'h1234, 32'h0, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("divz_lo", 6'd0, 6'd18, 32'h0, 32'h0, 32'h0, 26'h0, NPC, md(32'h3), NPC);
    txn("divz_hi", 6'd0, 6'd16, 32'h0, 32'h0, 32'h0, 26'h0, NPC, md(32'h1), NPC);
    txn("op1_nomod", 6'd1, 6'd17, 32'h9999, 32'h0, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("mthi", 6'd0, 6'd17, 32'hAAAA_5555, 32'h0, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("mtlo", 6'd0, 6'd19, 32'h1357_9BDF, 32'h0, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("mt_hi", 6'd0, 6'd16, 32'h0, 32'h0, 32'h0, 26'h0, NPC, md(32'hAAAA_5555), NPC);
    txn("mt_lo", 6'd0, 6'd18, 32'h0, 32'h0, 32'h0, 26'h0, NPC, md(32'h1357_9BDF), NPC);

    // Asynchronous clear between edges, then a write held across an edge under reset.
    #2;
    RSTN = 1'b0;
    #1;
    txn("arst_hi", 6'd0, 6'd16, 32'h0, 32'h0, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("arst_mthi", 6'd0, 6'd17, 32'h5, 32'h0, 32'h0, 26'h0, NPC, 32'h0, NPC);
    RSTN = 1'b1;
    txn("arst_lo", 6'd0, 6'd18, 32'h0, 32'h0, 32'h0, 26'h0, NPC, 32'h0, NPC);
    txn("arst_hi2", 6'd0, 6'd16, 32'h0, 32'h0, 32'h0, 26'h0, NPC, 32'h0, NPC);

    if (sb.size() != 0) check("sb_leftover", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameters: none; all datapaths fixed at 32 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset (ports CLK and RSTN).
REQ-003 CLK  in  1  rising-edge clock; only the HI/LO registers are clocked.
REQ-004 RSTN  in  1  asynchronous active-low reset.
REQ-005 Rdata1  in  32  rs operand.
REQ-006 Rdata2  in  32  rt operand.
REQ-007 ALU  in  6  funct field; decoded only when Op=0.
REQ-008 Op  in  6  opcode.
REQ-009 Ed32  in  32  sign-extended instr[15:0]; shamt is Ed32[10:6].
REQ-010 Jadr  in  26  jump target field.
REQ-011 nextPC  in  32  PC+4.
REQ-012 newPC  out  32  next fetch address.
REQ-013 Result  out  32  writeback value or memory address.

Function
REQ-014 Result and newPC SHALL be purely combinational from the inputs and HI/LO; zero latency.
REQ-015 Default: newPC=nextPC, Result=0 for any undecoded Op/ALU.
REQ-016 Op=0, ALU: 32/33 add, 34/35 sub, 36 and, 37 or, 38 xor, 39 nor; 42 SLT signed, 43 SLTU unsigned (Result 1 or 0).
REQ-017 All add/sub SHALL wrap modulo 2^32; overflow SHALL NOT trap or be flagged.
REQ-018 Shifts operate on Rdata2: 0 SLL, 2 SRL, 3 SRA by Ed32[10:6]; 4 SLLV, 6 SRLV, 7 SRAV by Rdata1[4:0]; SRA/SRAV replicate bit 31.
REQ-019 ALU 8 JR: newPC=Rdata1; ALU 9 JALR: newPC=Rdata1, Result=nextPC.
REQ-020 ALU 16 MFHI Result=HI; 18 MFLO Result=LO (current register value, pre-edge).
REQ-021 ALU 17 MTHI: HI<=Rdata1; 19 MTLO: LO<=Rdata1 at next CLK edge.
REQ-022 ALU 24 MULT / 25 MULTU: {HI,LO}<=64-bit signed/unsigned product at next edge.
REQ-023 ALU 26 DIV / 27 DIVU: LO<=quotient, HI<=remainder (signed truncating toward zero, remainder takes dividend sign / unsigned); divisor 0 SHALL leave HI and LO unchanged.
REQ-024 Op 8/9 ADDI/ADDIU: Rdata1+Ed32; 10 SLTI signed, 11 SLTIU unsigned compare Rdata1 vs Ed32.
REQ-025 Op 12/13/14 ANDI/ORI/XORI use zero-extended Ed32[15:0]; Op 15 LUI: {Ed32[15:0],16'h0}.
REQ-026 Op 0x20-0x2B (loads/stores): Result=Rdata1+Ed32.
REQ-027 Branches target nextPC+(Ed32<<2): Op 4 BEQ (Rdata1==Rdata2), 5 BNE, 6 BLEZ (signed Rdata1<=0), 7 BGTZ (>0); not taken newPC=nextPC; Result=0.
REQ-028 Op 2 J: newPC={nextPC[31:28],Jadr,2'b00}; Op 3 JAL: same plus Result=nextPC.
REQ-029 Ops not listed (incl. Op 1) SHALL follow REQ-015 and not modify HI/LO.

Reset
REQ-030 RSTN low SHALL clear HI and LO to 0 immediately, independent of CLK; reset dominates a coincident HI/LO write.
REQ-031 Outputs carry no reset state; they follow REQ-014 during reset (MFHI/MFLO read 0).

Configuration
REQ-032 Macro EX_MULDIV_EN defined: REQ-020..023 implemented. Undefined: HI/LO absent, ALU 16-19 and 24-27 yield Result=0 with no state change.

Structure
REQ-033 Opcode and funct localparams (OP_*, FN_*) SHALL live in shared package ex_pkg.
REQ-034 One sub-module ex_muldiv SHALL hold HI/LO and the multiply/divide logic; remaining ALU/branch logic stays in ex_stage.

Verification
REQ-035 Op=0, ALU=32, Rdata1=1, Rdata2=1 -> Result=2; ALU=39 -> Result=32'hFFFFFFFE.
REQ-036 ALU=42: (1,1) -> 0; (1,4) -> 1; Op=10, Rdata1=1, Ed32=4 -> 1; Op=11, Rdata1=1, Ed32=32'hFFFFFFFF -> 1.
REQ-037 ALU=24 with Rdata1=32'hFFFFFFFF, Rdata2=2, one edge -> MFHI=32'hFFFFFFFF, MFLO=32'hFFFFFFFE; MULTU same -> HI=1.
REQ-038 ALU=26, Rdata1=-7, Rdata2=2 -> LO=-3, HI=-1; divisor 0 -> HI/LO unchanged; RSTN low mid-test -> HI=LO=0 immediately.
REQ-039 Op=2, Jadr=26'h1, nextPC=32'h40000004 -> newPC=32'h40000004; Op=4 equal operands, Ed32=-1, nextPC=8 -> newPC=4.
REQ-040 ALU=3, Rdata2=32'h80000000, Ed32[10:6]=4 -> 32'hF8000000; Op=15, Ed32=32'h1234 -> 32'h12340000.
